fsk_window_scheduler: RTL

//  Sequences one frequency_analyzer instance into fixed-length measurement windows (one FSK symbol each).
//  Per window: clear analyzer, enable it for WINDOW_TICKS clocks, read f0/f1/unknown tick totals.

---
 rtl/fsk_pkg.sv | 18 +
 rtl/fsk_symbol_decider.sv | 38 +++
 rtl/fsk_window_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/fsk_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the FSK symbol path: scheduler states and symbol quality codes.
package fsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_MEAS   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_OK    = 2'b00;
  localparam logic [1:0] STATUS_WEAK  = 2'b01;
  localparam logic [1:0] STATUS_TIE   = 2'b10;
  localparam logic [1:0] STATUS_NOISY = 2'b11;

endpackage

// File: rtl/fsk_symbol_decider.sv
`timescale 1ns/1ps
// Combinational symbol decision from one window's f0/f1/unknown tick totals.
// Occupancy is compared as winner*100 against WINDOW_TICKS*MIN_OCCUPANCY_PCT in 40 bits
// so a full-scale 32-bit winner cannot overflow the product.
module fsk_symbol_decider
  import fsk_pkg::*;
#(
  parameter int WINDOW_TICKS      = 5000,
  parameter int MIN_OCCUPANCY_PCT = 75
) (
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  input  logic [31:0] unknown_value,
  output logic        symbol_bit,
  output logic [1:0]  symbol_status
);

  localparam logic [39:0] OCC_THRESHOLD = 40'(WINDOW_TICKS) * 40'(MIN_OCCUPANCY_PCT);

  logic [31:0] winner;
  logic [39:0] winner_scaled;

  // Pick the dominant tone and grade it; a tie outranks noise, noise outranks weak occupancy.
  always_comb begin
    symbol_bit    = (f1_value > f0_value);
    winner        = symbol_bit ? f1_value : f0_value;
    winner_scaled = {8'd0, winner} * 40'd100;
    symbol_status = STATUS_OK;
    if (f0_value == f1_value) begin
      symbol_status = STATUS_TIE;
    end else if (unknown_value > winner) begin
      symbol_status = STATUS_NOISY;
    end else if (winner_scaled < OCC_THRESHOLD) begin
      symbol_status = STATUS_WEAK;
    end
  end

endmodule

// File: rtl/fsk_window_scheduler.sv
`timescale 1ns/1ps
// Sequences a frequency analyzer through fixed-length measurement windows, grades each window
// into one FSK symbol and offers it on a valid/ready handshake. Dropped symbols are counted.
module fsk_window_scheduler
  import fsk_pkg::*;
#(
  parameter int WINDOW_TICKS      = 5000,
  parameter int MIN_OCCUPANCY_PCT = 75,
  parameter int OVERRUN_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     abort,
  output logic                     ana_clear,
  output logic                     ana_enable,
  input  logic [31:0]              f0_value,
  input  logic [31:0]              f1_value,
  input  logic [31:0]              unknown_value,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     result_bit,
  output logic [1:0]               result_status,
  output logic                     busy,
  output logic [OVERRUN_WIDTH-1:0] overrun_count
);

  localparam int              CNT_W    = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_TICKS - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             dec_bit;
  logic [1:0]       dec_status;
  logic             accept;
  logic             decide_now;

  fsk_symbol_decider #(
    .WINDOW_TICKS      (WINDOW_TICKS),
    .MIN_OCCUPANCY_PCT (MIN_OCCUPANCY_PCT)
  ) u_decider (
    .f0_value      (f0_value),
    .f1_value      (f1_value),
    .unknown_value (unknown_value),
    .symbol_bit    (dec_bit),
    .symbol_status (dec_status)
  );

  assign accept     = result_valid && result_ready;
  assign decide_now = (state == ST_DECIDE) && !abort;

  // Next-state and window down-counter; abort overrides every state.
  always_comb begin
    state_next = state;
    count_next = count;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_next = ST_CLR;
        end
        ST_CLR: begin
          state_next = ST_MEAS;
          count_next = CNT_LOAD;
        end
        ST_MEAS: begin
          if (count == '0) state_next = ST_SETTLE;
          else             count_next = count - CNT_W'(1);
        end
        ST_SETTLE: state_next = ST_DECIDE;
        ST_DECIDE: state_next = continuous ? ST_CLR : ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // State register; analyzer controls and busy are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= ST_IDLE;
      count      <= '0;
      ana_clear  <= 1'b0;
      ana_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      ana_clear  <= (state_next != ST_CLR);
      ana_enable <= (state_next == ST_MEAS);
      busy       <= (state_next != ST_IDLE);
    end
  end

  // Result register and saturating overrun counter; a held result is only replaced if consumed this cycle.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      result_valid  <= 1'b0;
      result_bit    <= 1'b0;
      result_status <= STATUS_OK;
      overrun_count <= '0;
    end else if (decide_now) begin
      if (!result_valid || accept) begin
        result_valid  <= 1'b1;
        result_bit    <= dec_bit;
        result_status <= dec_status;
      end else if (overrun_count != '1) begin
        overrun_count <= overrun_count + OVERRUN_WIDTH'(1);
      end
    end else if (accept) begin
      result_valid <= 1'b0;
    end
  end

endmodule
